cnt_mod: RTL and testbench

CNT_MOD -- requirements
Module: cnt_mod

---
 rtl/cnt_pkg.sv | 23 ++
 rtl/cnt_mod.sv | 91 +++++++++
 tb/tb_cnt_mod.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for modulo counters.
// Stopwatch chains build from cnt_mod instances using these moduli.
package cnt_pkg;

    localparam int CNT_CENTI = 100;
    localparam int CNT_SEC   = 60;
    localparam int CNT_MIN   = 60;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_mod.sv
// Up/down modulo counter with load, clear, wrap carry and divided clock.
// Chain stages by feeding each carry into the next stage's en.
module cnt_mod
    import cnt_pkg::*;
#(
    parameter int MODULO = 100,
    parameter int WIDTH  = clog2(MODULO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             out_clk,
    output logic             load_err
);

    localparam int HALF = MODULO / 2;

    localparam logic [WIDTH:0] MOD  = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] MAX  = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] HF   = (WIDTH+1)'(HALF);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

    logic [WIDTH:0] cur;
    logic [WIDTH:0] nxt;
    logic [WIDTH:0] lv;
    logic           wr;
    logic           wrap;
    logic           lerr;

    // Extra bit keeps the out-of-range load compare exact at 2**WIDTH.
    always_comb begin
        cur  = {1'b0, value};
        lv   = {1'b0, load_val};
        nxt  = cur;
        wr   = 1'b0;
        wrap = 1'b0;
        lerr = 1'b0;
        if (clr) begin
            nxt = '0;
            wr  = 1'b1;
        end else if (load) begin
            wr = 1'b1;
            if (lv >= MOD) begin
                nxt  = MAX;
                lerr = 1'b1;
            end else begin
                nxt = lv;
            end
        end else if (en) begin
            wr = 1'b1;
            if (up_dn) begin
                if (cur == MAX) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = cur + ONE;
                end
            end else begin
                if (cur == '0) begin
                    nxt  = MAX;
                    wrap = 1'b1;
                end else begin
                    nxt = cur - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value    <= '0;
            carry    <= 1'b0;
            out_clk  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            value    <= nxt[WIDTH-1:0];
            carry    <= wrap;
            load_err <= lerr;
            if (wr) begin
                out_clk <= (nxt < HF);
            end
        end
    end

endmodule

// File: tb/tb_cnt_mod.sv
// Bench for cnt_mod: several moduli plus a two-stage chain,
// compared cycle by cycle against an arithmetic reference model.
module tb_cnt_mod;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       up_dn;
    logic       load;
    logic [6:0] lv;
    logic       ch_en;

    logic [6:0] v100;
    logic [5:0] v60;
    logic [1:0] v3;
    logic [6:0] vc0;
    logic [5:0] vc1;
    logic       c100, c60, c3, cc0, cc1;
    logic       o100, o60, o3, oc0, oc1;
    logic       e100, e60, e3, ec0, ec1;

    int   errors;
    int   checks;

    int   dval[5];
    logic dc[5];
    logic dox[5];
    logic de[5];

    int   mod[5];
    int   mask[5];
    int   mv[5];
    int   mc[5];
    int   mo[5];
    int   me[5];

    cnt_mod #(.MODULO(100)) u100 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn),
        .load(load), .load_val(lv), .value(v100), .carry(c100),
        .out_clk(o100), .load_err(e100)
    );

    cnt_mod #(.MODULO(60)) u60 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn),
        .load(load), .load_val(lv[5:0]), .value(v60), .carry(c60),
        .out_clk(o60), .load_err(e60)
    );

    cnt_mod #(.MODULO(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up_dn(up_dn),
        .load(load), .load_val(lv[1:0]), .value(v3), .carry(c3),
        .out_clk(o3), .load_err(e3)
    );

    cnt_mod #(.MODULO(100)) uc0 (
        .clk(clk), .rst(rst), .en(ch_en), .clr(1'b0), .up_dn(1'b1),
        .load(1'b0), .load_val(7'd0), .value(vc0), .carry(cc0),
        .out_clk(oc0), .load_err(ec0)
    );

    cnt_mod #(.MODULO(60)) uc1 (
        .clk(clk), .rst(rst), .en(cc0), .clr(1'b0), .up_dn(1'b1),
        .load(1'b0), .load_val(6'd0), .value(vc1), .carry(cc1),
        .out_clk(oc1), .load_err(ec1)
    );

    assign dval[0] = int'(v100);
    assign dval[1] = int'(v60);
    assign dval[2] = int'(v3);
    assign dval[3] = int'(vc0);
    assign dval[4] = int'(vc1);
    assign dc[0] = c100;
    assign dc[1] = c60;
    assign dc[2] = c3;
    assign dc[3] = cc0;
    assign dc[4] = cc1;
    assign dox[0] = o100;
    assign dox[1] = o60;
    assign dox[2] = o3;
    assign dox[3] = oc0;
    assign dox[4] = oc1;
    assign de[0] = e100;
    assign de[1] = e60;
    assign de[2] = e3;
    assign de[3] = ec0;
    assign de[4] = ec1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mv[i] = 0;
            mc[i] = 0;
            mo[i] = 0;
            me[i] = 0;
        end
    endtask

    // Advance one rising edge and apply the counting rules to the model.
    task automatic tick();
        int m, ie, ic, il, iu, ival;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 4; i >= 0; i--) begin
                m    = mod[i];
                ie   = (i < 3) ? int'(en) : (i == 3 ? int'(ch_en) : mc[3]);
                ic   = (i < 3) ? int'(clr) : 0;
                il   = (i < 3) ? int'(load) : 0;
                iu   = (i < 3) ? int'(up_dn) : 1;
                ival = (i < 3) ? (int'(lv) & mask[i]) : 0;
                mc[i] = 0;
                me[i] = 0;
                if (ic != 0) begin
                    mv[i] = 0;
                    mo[i] = 1;
                end else if (il != 0) begin
                    if (ival >= m) begin
                        mv[i] = m - 1;
                        me[i] = 1;
                    end else begin
                        mv[i] = ival;
                    end
                    mo[i] = (mv[i] < m / 2) ? 1 : 0;
                end else if (ie != 0) begin
                    if (iu != 0) begin
                        mc[i] = (mv[i] == m - 1) ? 1 : 0;
                        mv[i] = (mv[i] + 1) % m;
                    end else begin
                        mc[i] = (mv[i] == 0) ? 1 : 0;
                        mv[i] = (mv[i] + m - 1) % m;
                    end
                    mo[i] = (mv[i] < m / 2) ? 1 : 0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic u,
                         input logic l, input logic [6:0] val);
        en    = e;
        clr   = c;
        up_dn = u;
        load  = l;
        lv    = val;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dval[i] !== 0 || dc[i] !== 1'b0 ||
                dox[i] !== 1'b0 || de[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d got v=%0d c=%b o=%b e=%b want 0 0 0 0",
                         i, dval[i], dc[i], dox[i], de[i]);
            end
        end
        tick();
        rst = 1'b1;
        checks++;
        if (dval[0] !== 0 || dox[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got v=%0d o=%b want 0 0", dval[0], dox[0]);
        end
    endtask

    task automatic test_up_wrap();
        int ncar, nhi;
        ncar = 0;
        nhi  = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (dc[0] === 1'b1) ncar++;
            if (k > 100 && dox[0] === 1'b1) nhi++;
            checks++;
            if (dval[0] !== (k % 100) || dc[0] !== 1'(mc[0]) ||
                dox[0] !== 1'(mo[0])) begin
                errors++;
                $display("FAIL up_wrap k=%0d got v=%0d c=%b o=%b want %0d %0d %0d",
                         k, dval[0], dc[0], dox[0], k % 100, mc[0], mo[0]);
            end
        end
        checks++;
        if (ncar !== 2) begin
            errors++;
            $display("FAIL up_carry_count got %0d want 2", ncar);
        end
        checks++;
        if (nhi !== 50) begin
            errors++;
            $display("FAIL up_outclk_high got %0d want 50", nhi);
        end
    endtask

    task automatic test_down();
        int ncar;
        ncar = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        tick();
        checks++;
        if (dval[1] !== 59 || dc[1] !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap got v=%0d c=%b want 59 1", dval[1], dc[1]);
        end
        for (int k = 0; k < 59; k++) begin
            tick();
            if (dc[1] === 1'b1) ncar++;
        end
        checks++;
        if (dval[1] !== 0 || ncar !== 0) begin
            errors++;
            $display("FAIL down_end got v=%0d carries=%0d want 0 0", dval[1], ncar);
        end
    endtask

    task automatic test_mod3();
        int nhi;
        nhi = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (dox[2] === 1'b1) nhi++;
            checks++;
            if (dox[2] !== (dval[2] == 0 ? 1'b1 : 1'b0) || dval[2] !== mv[2]) begin
                errors++;
                $display("FAIL mod3_pat got v=%0d o=%b want v=%0d o=%0d",
                         dval[2], dox[2], mv[2], mv[2] == 0);
            end
        end
        checks++;
        if (nhi !== 3) begin
            errors++;
            $display("FAIL mod3_high got %0d want 3", nhi);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd120);
        tick();
        checks++;
        if (dval[0] !== 99 || de[0] !== 1'b1 || dc[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_bad got v=%0d e=%b c=%b want 99 1 0",
                     dval[0], de[0], dc[0]);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        tick();
        checks++;
        if (dval[0] !== 99 || de[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_err_pulse got v=%0d e=%b want 99 0", dval[0], de[0]);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd42);
        tick();
        checks++;
        if (dval[0] !== 42 || de[0] !== 1'b0 || dox[0] !== 1'b1) begin
            errors++;
            $display("FAIL load_ok got v=%0d e=%b o=%b want 42 0 1",
                     dval[0], de[0], dox[0]);
        end
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd37);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd5);
        tick();
        checks++;
        if (dval[0] !== 0 || dc[0] !== 1'b0 || dox[0] !== 1'b1) begin
            errors++;
            $display("FAIL priority got v=%0d c=%b o=%b want 0 0 1",
                     dval[0], dc[0], dox[0]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd99);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dval[0] !== 0 || dc[0] !== 1'b0 || dox[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got v=%0d c=%b o=%b want 0 0 0",
                     dval[0], dc[0], dox[0]);
        end
        tick();
        checks++;
        if (dval[0] !== 0 || dc[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got v=%0d c=%b want 0 0", dval[0], dc[0]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dval[0] !== 1 || dc[0] !== 1'b0 || dox[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_resume got v=%0d c=%b o=%b want 1 0 1",
                     dval[0], dc[0], dox[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  7'($urandom_range(0, 127)));
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dval[i] !== mv[i] || dc[i] !== 1'(mc[i]) ||
                    dox[i] !== 1'(mo[i]) || de[i] !== 1'(me[i])) begin
                    errors++;
                    $display("FAIL random k=%0d inst%0d got %0d %b %b %b want %0d %0d %0d %0d",
                             k, i, dval[i], dc[i], dox[i], de[i],
                             mv[i], mc[i], mo[i], me[i]);
                end
            end
        end
    endtask

    task automatic test_chain();
        int ncar;
        ncar = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        ch_en = 1'b1;
        // Upper stage lags by one edge because carry is registered.
        for (int k = 1; k <= 6001; k++) begin
            tick();
            if (dc[4] === 1'b1) ncar++;
            if (k == 6000) begin
                checks++;
                if (dval[3] !== 0 || dc[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL chain_low got v=%0d c=%b want 0 1", dval[3], dc[3]);
                end
            end
            if (k % 500 == 0) begin
                checks++;
                if (dval[3] !== mv[3] || dval[4] !== mv[4]) begin
                    errors++;
                    $display("FAIL chain_track k=%0d got %0d %0d want %0d %0d",
                             k, dval[3], dval[4], mv[3], mv[4]);
                end
            end
        end
        ch_en = 1'b0;
        checks++;
        if (dval[4] !== 0 || ncar !== 1 || dc[4] !== 1'b1) begin
            errors++;
            $display("FAIL chain_upper got v=%0d carries=%0d c=%b want 0 1 1",
                     dval[4], ncar, dc[4]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mod[0] = 100; mask[0] = 127;
        mod[1] = 60;  mask[1] = 63;
        mod[2] = 3;   mask[2] = 3;
        mod[3] = 100; mask[3] = 127;
        mod[4] = 60;  mask[4] = 63;
        model_reset();
        rst   = 1'b0;
        ch_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        test_reset();
        test_up_wrap();
        test_down();
        test_mod3();
        test_load();
        test_priority();
        test_reset_mid();
        test_random();
        test_chain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
